// File: rtl/dm_access_unit_if.sv
// -----------------------------------------------------------------------------
// dm_access_unit_if
// Request/acknowledge data-memory bus between the DM access unit (master) and
// the data memory (slave).
//   bus_req    master -> slave  request, held high until bus_ack
//   bus_we     master -> slave  1 = write, 0 = read
//   bus_addr   master -> slave  word-aligned byte address
//   bus_wdata  master -> slave  store data
//   bus_ack    slave  -> master one-cycle completion pulse
//   bus_rdata  slave  -> master load data, valid with bus_ack
// -----------------------------------------------------------------------------
interface dm_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dm_access_unit.sv
// -----------------------------------------------------------------------------
// dm_access_unit
// Data-memory stage. Consumes the EX/DM pipeline register, turns loads and
// stores into one req/ack transaction on the data-memory bus, stalls the
// upstream pipeline while the access is outstanding and registers the result
// toward the DM/WB register. Non-memory instructions pass through in a cycle.
//
// Ports
//   clk, reset         clock, asynchronous active-low reset
//   mem_read_in ..     EX/DM inputs (mem_read/mem_write/mem_to_reg/reg_write,
//   write_data_in      rd, byte address, store data)
//   bus                data-memory bus (master side)
//   stall              combinational freeze of PC, IF/ID, ID/EX, EX/DM
//   *_out              DM/WB register outputs
//   misalign_err       one-cycle pulse: memory op with addr[1:0] != 0
//   timeout_err        one-cycle pulse: access aborted, no ack within TIMEOUT
// -----------------------------------------------------------------------------
module dm_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15   // 1..255 ACCESS cycles without ack before abort
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_to_reg_in,
  input  logic              reg_write_in,
  input  logic [4:0]        rd_in,
  input  logic [ADDR_W-1:0] mem_address_in,
  input  logic [DATA_W-1:0] write_data_in,
  dm_access_unit_if.master  bus,
  output logic              stall,
  output logic [DATA_W-1:0] read_data_out,
  output logic [ADDR_W-1:0] alu_result_out,
  output logic [4:0]        rd_out,
  output logic              reg_write_out,
  output logic              mem_to_reg_out,
  output logic              misalign_err,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic              w_stall;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_is_load;
  logic [7:0]        r_cnt;
  logic              r_abort;
  logic [DATA_W-1:0] r_rdata_buf;

  logic              w_mem_op;
  logic              w_misaligned;
  logic              w_start;
  logic              w_ack;
  logic              w_abort_now;

  assign w_mem_op     = mem_read_in | mem_write_in;
  assign w_misaligned = w_mem_op & (|mem_address_in[1:0]);
  assign w_start      = (r_state == S_IDLE) & w_mem_op & ~w_misaligned;
  // bus_ack only counts while a request is outstanding; stray pulses are ignored.
  assign w_ack        = (r_state == S_ACCESS) & bus.bus_ack;
  // Ack in the last allowed cycle wins over the abort.
  assign w_abort_now  = (r_state == S_ACCESS) & ~bus.bus_ack & (r_cnt == LAST_CNT);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: state is updated with <= so every flop samples pre-edge values.
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and stall
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    w_next_state = r_state;
    w_stall      = 1'b0;
    case (r_state)
      S_IDLE:   if (w_start) w_next_state = S_ACCESS;
      S_ACCESS: if (w_ack || w_abort_now) w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;   // served op is never reissued
      default:  w_next_state = S_IDLE;
    endcase
    w_stall = w_start | (r_state == S_ACCESS);
  end

  // While reset is held the pipeline must not be frozen by a stale EX/DM op.
  assign stall = reset & w_stall;

  // ---------------------------------------------------------------------------
  // Transaction datapath: latched request, cycle counter, load buffer, errors
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: every register here is a plain flop, so all get a reset value;
      // there is no storage array that would need to be left unreset.
      r_addr         <= '0;
      r_wdata        <= '0;
      r_we           <= 1'b0;
      r_is_load      <= 1'b0;
      r_cnt          <= '0;
      r_abort        <= 1'b0;
      r_rdata_buf    <= '0;
      misalign_err   <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      misalign_err <= (r_state == S_IDLE) & w_misaligned;
      timeout_err  <= w_abort_now;
      if (w_start) begin
        r_addr    <= {mem_address_in[ADDR_W-1:2], 2'b00};
        r_wdata   <= write_data_in;
        r_we      <= mem_write_in;           // read+write together is a write
        r_is_load <= ~mem_write_in;
        r_cnt     <= '0;
        r_abort   <= 1'b0;
      end
      if (r_state == S_ACCESS) begin
        r_cnt <= r_cnt + 8'd1;
        if (w_ack && r_is_load) r_rdata_buf <= bus.bus_rdata;
        if (w_abort_now)        r_abort     <= 1'b1;
      end
    end
  end

  assign bus.bus_req   = (r_state == S_ACCESS);
  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_wdata = r_wdata;

  // ---------------------------------------------------------------------------
  // DM/WB register: bubble while stalled, otherwise capture the EX/DM op
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data_out  <= '0;
      alu_result_out <= '0;
      rd_out         <= '0;
      reg_write_out  <= 1'b0;
      mem_to_reg_out <= 1'b0;
    end else if (w_stall) begin
      reg_write_out <= 1'b0;
    end else begin
      rd_out         <= rd_in;
      mem_to_reg_out <= mem_to_reg_in;
      alu_result_out <= mem_address_in;
      reg_write_out  <= reg_write_in & ~w_misaligned &
                        ~((r_state == S_DONE) & r_abort & r_is_load);
      read_data_out  <= ((r_state == S_DONE) && r_is_load) ? r_rdata_buf : '0;
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// -----------------------------------------------------------------------------
// tb_dm_access_unit
// Directed scenarios followed by randomized instructions. Each instruction is
// described at transaction level (kind, address, ack cycle) and the expected
// stall length, bus activity and DM/WB result are computed from those values.
// -----------------------------------------------------------------------------
module tb_dm_access_unit;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in;
  logic [4:0]        rd_in;
  logic [ADDR_W-1:0] mem_address_in;
  logic [DATA_W-1:0] write_data_in;
  logic              stall;
  logic [DATA_W-1:0] read_data_out;
  logic [ADDR_W-1:0] alu_result_out;
  logic [4:0]        rd_out;
  logic              reg_write_out, mem_to_reg_out, misalign_err, timeout_err;

  dm_access_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

  dm_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .mem_to_reg_in  (mem_to_reg_in),
    .reg_write_in   (reg_write_in),
    .rd_in          (rd_in),
    .mem_address_in (mem_address_in),
    .write_data_in  (write_data_in),
    .bus            (bus_if.master),
    .stall          (stall),
    .read_data_out  (read_data_out),
    .alu_result_out (alu_result_out),
    .rd_out         (rd_out),
    .reg_write_out  (reg_write_out),
    .mem_to_reg_out (mem_to_reg_out),
    .misalign_err   (misalign_err),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] last_rdata;   // model of the load buffer: data of last completed load

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_nop();
    mem_read_in    = 1'b0;
    mem_write_in   = 1'b0;
    mem_to_reg_in  = 1'b0;
    reg_write_in   = 1'b0;
    rd_in          = '0;
    mem_address_in = '0;
    write_data_in  = '0;
  endtask

  // One instruction through the stage. ack_at = ACCESS cycle (1-based) in which
  // the memory acknowledges; a value above TIMEOUT means it never does.
  task automatic run_op(input string tag, input bit rd_en, input bit wr_en,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input bit rw, input bit m2r,
                        input int ack_at, input logic [31:0] rdata);
    bit mem_op, mis, served, is_load, abort, done;
    int n_acc, exp_stall, stalled, acc;

    mem_op    = rd_en | wr_en;
    mis       = mem_op && (addr[1:0] != 2'b00);
    served    = mem_op && !mis;
    is_load   = !wr_en;
    abort     = served && (ack_at > TIMEOUT);
    n_acc     = served ? ((ack_at > TIMEOUT) ? TIMEOUT : ack_at) : 0;
    exp_stall = served ? 1 + n_acc : 0;
    stalled   = 0;
    acc       = 0;
    done      = 1'b0;

    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    mem_read_in    = rd_en;
    mem_write_in   = wr_en;
    mem_to_reg_in  = m2r;
    reg_write_in   = rw;
    rd_in          = rd;
    mem_address_in = addr;
    write_data_in  = wdata;

    for (int guard = 0; guard < 64; guard++) begin
      #1;
      if (!stall) begin
        done = 1'b1;
        break;
      end
      if (stalled > 0) check({tag, ":bubble"}, 32'(reg_write_out), 32'd0);
      if (bus_if.bus_req) begin
        acc++;
        check({tag, ":bus_we"},   32'(bus_if.bus_we), 32'(wr_en));
        check({tag, ":bus_addr"}, bus_if.bus_addr, addr);
        if (wr_en) check({tag, ":bus_wdata"}, bus_if.bus_wdata, wdata);
        bus_if.bus_ack   = (acc == ack_at);
        bus_if.bus_rdata = (acc == ack_at) ? rdata : $urandom();
      end else begin
        // request not yet on the bus: a stray ack here must be ignored
        bus_if.bus_ack   = 1'($urandom_range(0, 1));
        bus_if.bus_rdata = $urandom();
      end
      stalled++;
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
    end

    check({tag, ":terminated"}, 32'(done), 32'd1);
    check({tag, ":stall_cycles"}, 32'(stalled), 32'(exp_stall));
    check({tag, ":req_cycles"}, 32'(acc), 32'(n_acc));
    check({tag, ":req_low_at_end"}, 32'(bus_if.bus_req), 32'd0);
    if (served) begin
      check({tag, ":timeout_err"}, 32'(timeout_err), 32'(abort));
      if (abort) begin
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = $urandom();
      end
    end

    @(posedge clk);
    #1;
    bus_if.bus_ack = 1'b0;
    if (served && is_load && !abort) last_rdata = rdata;

    check({tag, ":rd_out"},         32'(rd_out), 32'(rd));
    check({tag, ":alu_result_out"}, alu_result_out, addr);
    check({tag, ":mem_to_reg_out"}, 32'(mem_to_reg_out), 32'(m2r));
    check({tag, ":reg_write_out"},  32'(reg_write_out),
          32'(rw && !mis && !(abort && is_load)));
    check({tag, ":read_data_out"},  read_data_out,
          (served && is_load) ? last_rdata : 32'd0);
    check({tag, ":misalign_err"},   32'(misalign_err), 32'(mis));
    check({tag, ":timeout_pulse"},  32'(timeout_err), 32'd0);
    check({tag, ":req_idle"},       32'(bus_if.bus_req), 32'd0);

    // Pipeline advances to a bubble; stray acks keep arriving and are ignored.
    @(negedge clk);
    set_nop();
    bus_if.bus_ack   = 1'($urandom_range(0, 1));
    bus_if.bus_rdata = $urandom();
    @(posedge clk);
    #1;
    bus_if.bus_ack = 1'b0;
    check({tag, ":misalign_pulse"}, 32'(misalign_err), 32'd0);
    check({tag, ":nop_req"},        32'(bus_if.bus_req), 32'd0);
    check({tag, ":nop_reg_write"},  32'(reg_write_out), 32'd0);
  endtask

  initial begin
    logic [31:0] a, w;
    int k;

    reset            = 1'b0;
    set_nop();
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;
    last_rdata       = '0;

    #2;
    check("reset:bus_req",        32'(bus_if.bus_req), 32'd0);
    check("reset:stall",          32'(stall), 32'd0);
    check("reset:reg_write_out",  32'(reg_write_out), 32'd0);
    check("reset:read_data_out",  read_data_out, 32'd0);
    check("reset:alu_result_out", alu_result_out, 32'd0);
    check("reset:errors",         32'({misalign_err, timeout_err}), 32'd0);

    @(negedge clk);
    reset = 1'b1;

    // Directed scenarios
    run_op("nonmem",     1'b0, 1'b0, 32'h10, 32'h0,    5'd5,  1'b1, 1'b0, 1,  32'h0);
    run_op("load_ack3",  1'b1, 1'b0, 32'h40, 32'h0,    5'd7,  1'b1, 1'b1, 3,  32'hCAFEF00D);
    run_op("store",      1'b0, 1'b1, 32'h8,  32'h1234, 5'd0,  1'b0, 1'b0, 2,  32'h0);
    run_op("misalign",   1'b1, 1'b0, 32'h41, 32'h0,    5'd9,  1'b1, 1'b1, 1,  32'h0);
    run_op("timeout",    1'b1, 1'b0, 32'h80, 32'h0,    5'd3,  1'b1, 1'b1, 99, 32'h0);
    run_op("ack_first",  1'b1, 1'b0, 32'hC0, 32'h0,    5'd4,  1'b1, 1'b1, 1,  32'h11112222);
    run_op("ack_last",   1'b1, 1'b0, 32'hC4, 32'h0,    5'd6,  1'b1, 1'b1, TIMEOUT, 32'h33334444);
    run_op("ack_late",   1'b1, 1'b0, 32'hC8, 32'h0,    5'd8,  1'b1, 1'b1, TIMEOUT + 1, 32'h0);
    run_op("rd_and_wr",  1'b1, 1'b1, 32'h20, 32'hBEEF, 5'd2,  1'b0, 1'b0, 4,  32'h0);

    // Reset in the middle of an access
    @(negedge clk);
    mem_read_in    = 1'b1;
    reg_write_in   = 1'b1;
    rd_in          = 5'd12;
    mem_address_in = 32'h100;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid:req_before", 32'(bus_if.bus_req), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_mid:bus_req",       32'(bus_if.bus_req), 32'd0);
    check("rst_mid:stall",         32'(stall), 32'd0);
    check("rst_mid:reg_write_out", 32'(reg_write_out), 32'd0);
    check("rst_mid:read_data_out", read_data_out, 32'd0);
    last_rdata = '0;
    @(negedge clk);
    set_nop();
    @(negedge clk);
    reset = 1'b1;
    run_op("after_rst", 1'b1, 1'b0, 32'h104, 32'h0, 5'd12, 1'b1, 1'b1, 2, 32'h5A5A5A5A);

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      k = int'($urandom_range(0, 4));
      a = $urandom() & 32'hFFFF_FFFC;
      w = $urandom();
      case (k)
        0: run_op("rnd_nop",   1'b0, 1'b0, $urandom(), w, 5'($urandom()), 1'($urandom()),
                  1'($urandom()), 1, 32'h0);
        1: run_op("rnd_load",  1'b1, 1'b0, a, w, 5'($urandom()), 1'($urandom()),
                  1'($urandom()), int'($urandom_range(1, TIMEOUT + 2)), $urandom());
        2: run_op("rnd_store", 1'b0, 1'b1, a, w, 5'($urandom()), 1'($urandom()),
                  1'($urandom()), int'($urandom_range(1, TIMEOUT + 2)), $urandom());
        3: run_op("rnd_both",  1'b1, 1'b1, a, w, 5'($urandom()), 1'($urandom()),
                  1'($urandom()), int'($urandom_range(1, TIMEOUT + 2)), $urandom());
        default: run_op("rnd_misalign", 1'($urandom()), 1'b1,
                  a | 32'($urandom_range(1, 3)), w, 5'($urandom()), 1'($urandom()),
                  1'($urandom()), 1, 32'h0);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
